// File: rtl/sram_bank_pkg.sv
// Shared width helpers, row types and word-order functions for the SRAM bank generator.
package sram_bank_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_FETCH_WIDTH = 4;
  localparam int unsigned DEF_ROW_WIDTH   = DEF_DATA_WIDTH * DEF_FETCH_WIDTH;

  typedef logic [DEF_DATA_WIDTH-1:0]          fetch_word_t;
  typedef logic [DEF_ROW_WIDTH-1:0]           sram_row_t;
  typedef fetch_word_t [DEF_FETCH_WIDTH-1:0]  fetch_row_t;

  // Address field width for n items; a single item needs no field.
  function automatic int unsigned field_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  function automatic int unsigned min_one(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

  // Word i occupies row bits [i*DATA_WIDTH +: DATA_WIDTH] in both directions.
  function automatic sram_row_t flatten_row(input fetch_row_t words);
    sram_row_t row;
    for (int unsigned i = 0; i < DEF_FETCH_WIDTH; i++) begin
      row[i*DEF_DATA_WIDTH +: DEF_DATA_WIDTH] = words[i];
    end
    return row;
  endfunction

  function automatic fetch_row_t unflatten_row(input sram_row_t row);
    fetch_row_t words;
    for (int unsigned i = 0; i < DEF_FETCH_WIDTH; i++) begin
      words[i] = row[i*DEF_DATA_WIDTH +: DEF_DATA_WIDTH];
    end
    return words;
  endfunction

endpackage

// File: rtl/sram_bank_generator_slice.sv
// One single-port macro with its active-low chip/write enable conversion.
module sram_macro_slice #(
  parameter  int unsigned ROW_WIDTH = 64,
  parameter  int unsigned DEPTH     = 256,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 ce,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [ROW_WIDTH-1:0] d,
  input  logic [1:0]           rtsel,
  input  logic [1:0]           wtsel,
  output logic                 ceb,
  output logic [ROW_WIDTH-1:0] q
);

  logic                 web;
  logic [ROW_WIDTH-1:0] mem [DEPTH];
  logic                 unused_tsel;

  assign ceb = ~ce;
  assign web = ~(ce & we);

  // Timing selects only tune the foundry macro; this behavioural model ignores them.
  assign unused_tsel = ^{rtsel, wtsel};

  always_ff @(posedge clk) begin
    if (!ceb) begin
      if (!web) begin
        mem[addr] <= d;
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sram_bank_generator.sv
// Depth-tiled SRAM bank: write-priority arbitration, chain filtering, held read data.
// Optional output pipeline stage: define SRAM_BANK_OUT_REG_EN.
module sram_bank_generator
  import sram_bank_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH      = 16,
  parameter  int unsigned FETCH_WIDTH     = 4,
  parameter  int unsigned MACRO_DEPTH     = 256,
  parameter  int unsigned NUM_MACROS      = 2,
  parameter  int unsigned CHAIN_IDX_WIDTH = 2,
  parameter  int unsigned CHAIN_IDX       = 0,
  localparam int unsigned SEL_WIDTH       = field_width(NUM_MACROS),
  localparam int unsigned ROW_ADDR_WIDTH  = $clog2(MACRO_DEPTH),
  localparam int unsigned ADDR_WIDTH      = CHAIN_IDX_WIDTH + SEL_WIDTH + ROW_ADDR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clk_en,
  input  logic                                  chain_en,
  input  logic                                  wr_en,
  input  logic [ADDR_WIDTH-1:0]                 wr_addr,
  input  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] wr_data,
  output logic                                  wr_ready,
  input  logic                                  rd_en,
  input  logic [ADDR_WIDTH-1:0]                 rd_addr,
  output logic                                  rd_ready,
  output logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] rd_data,
  output logic                                  rd_valid,
  input  logic [1:0]                            rtsel,
  input  logic [1:0]                            wtsel
);

  localparam int unsigned ROW_WIDTH     = DATA_WIDTH * FETCH_WIDTH;
  localparam int unsigned SEL_REG_WIDTH = min_one(SEL_WIDTH);

  logic                                   wr_acc, rd_acc, hit;
  logic [ADDR_WIDTH-1:0]                  acc_addr;
  logic [CHAIN_IDX_WIDTH-1:0]             acc_chain;
  logic [ROW_ADDR_WIDTH-1:0]              acc_row;
  logic [SEL_REG_WIDTH-1:0]               acc_sel, sel_q;
  logic                                   rd_hit_q;
  logic [NUM_MACROS-1:0]                  ceb;
  logic [ROW_WIDTH-1:0]                   q [NUM_MACROS];
  logic [ROW_WIDTH-1:0]                   wr_row, q_mux;
  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] q_words, hold_q, rd_data_s1;
  logic                                   rd_valid_s1;

  assign wr_ready = clk_en & ~rst;
  assign rd_ready = clk_en & ~wr_en & ~rst;
  assign wr_acc   = wr_en & wr_ready;
  assign rd_acc   = rd_en & rd_ready;

  assign acc_addr  = wr_acc ? wr_addr : rd_addr;
  assign acc_chain = acc_addr[ADDR_WIDTH-1 -: CHAIN_IDX_WIDTH];
  assign acc_row   = acc_addr[ROW_ADDR_WIDTH-1:0];
  assign hit       = ~chain_en | (acc_chain == CHAIN_IDX_WIDTH'(CHAIN_IDX));

  if (SEL_WIDTH > 0) begin : g_sel
    assign acc_sel = acc_addr[ROW_ADDR_WIDTH +: SEL_WIDTH];
  end else begin : g_no_sel
    assign acc_sel = '0;
  end

  // Row mapping uses the package helpers when the widths match their types.
  if (DATA_WIDTH == DEF_DATA_WIDTH && FETCH_WIDTH == DEF_FETCH_WIDTH) begin : g_pkg_map
    assign wr_row  = flatten_row(wr_data);
    assign q_words = unflatten_row(q_mux);
  end else begin : g_gen_map
    for (genvar w = 0; w < FETCH_WIDTH; w++) begin : g_word
      assign wr_row[w*DATA_WIDTH +: DATA_WIDTH] = wr_data[w];
      assign q_words[w] = q_mux[w*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar m = 0; m < NUM_MACROS; m++) begin : g_macro
    logic ce;
    assign ce = (wr_acc | rd_acc) & hit & (acc_sel == SEL_REG_WIDTH'(m));
    sram_macro_slice #(
      .ROW_WIDTH (ROW_WIDTH),
      .DEPTH     (MACRO_DEPTH)
    ) u_slice (
      .clk   (clk),
      .ce    (ce),
      .we    (wr_acc),
      .addr  (acc_row),
      .d     (wr_row),
      .rtsel (rtsel),
      .wtsel (wtsel),
      .ceb   (ceb[m]),
      .q     (q[m])
    );
  end

  assign q_mux = q[sel_q];

  // A read that actually enabled a macro returns data next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      rd_hit_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      rd_hit_q <= rd_acc & ~(&ceb);
      if (rd_acc) sel_q <= acc_sel;
      if (rd_valid_s1) hold_q <= q_words;
    end
  end

  assign rd_valid_s1 = rd_hit_q & ~rst;
  assign rd_data_s1  = rd_valid_s1 ? q_words : hold_q;

`ifdef SRAM_BANK_OUT_REG_EN
  logic                                   valid_q2;
  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] data_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q2 <= 1'b0;
      data_q2  <= '0;
    end else begin
      valid_q2 <= rd_valid_s1;
      data_q2  <= rd_data_s1;
    end
  end

  assign rd_valid = valid_q2;
  assign rd_data  = data_q2;
`else
  assign rd_valid = rd_valid_s1;
  assign rd_data  = rd_data_s1;
`endif

endmodule

// File: tb/tb_sram_bank_generator.sv
// Directed self-checking bench for sram_bank_generator at default parameters.
module tb_sram_bank_generator;

`ifdef SRAM_BANK_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [3:0][15:0] row_t;

  logic        clk = 1'b0;
  logic        rst, clk_en, chain_en, wr_en, rd_en;
  logic [10:0] wr_addr, rd_addr;
  row_t        wr_data, rd_data;
  logic        wr_ready, rd_ready, rd_valid;
  logic [1:0]  rtsel, wtsel;

  int checks   = 0;
  int failures = 0;

  row_t row_a, row_b, row_c, row_d, row_e;

  sram_bank_generator dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .chain_en (chain_en),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rtsel    (rtsel),
    .wtsel    (wtsel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1; chain_en = 1'b0;
    wr_en = 1'b1; rd_en = 1'b1; wr_addr = 11'h005; rd_addr = 11'h005;
    wr_data = '0; rtsel = 2'b01; wtsel = 2'b10;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (rd_ready !== 1'b0) begin failures++; $display("FAIL reset_rd_ready: got %b expected 0", rd_ready); end
    checks++; if (dut.ceb !== 2'b11) begin failures++; $display("FAIL reset_ceb: got %b expected 11", dut.ceb); end
    tick(); tick();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    wr_en = 1'b1; wr_addr = 11'h005; wr_data = row_a;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL basic_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (dut.ceb !== 2'b10) begin failures++; $display("FAIL basic_wr_ceb: got %b expected 10", dut.ceb); end
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 11'h005;
    @(negedge clk);
    checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL basic_rd_ready: got %b expected 1", rd_ready); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", rd_valid); end
    tick();
    rd_en = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL basic_latency: got %b expected 0", rd_valid); end
      tick();
    end
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL basic_rd_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_data !== row_a) begin failures++; $display("FAIL basic_rd_data: got %h expected %h", rd_data, row_a); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_pulse: got %b expected 0", rd_valid); end
  endtask

  task automatic test_macro_select();
    wr_en = 1'b1; wr_addr = 11'h105; wr_data = row_b;
    @(negedge clk);
    checks++; if (dut.ceb !== 2'b01) begin failures++; $display("FAIL sel_wr_ceb: got %b expected 01", dut.ceb); end
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 11'h005;
    @(negedge clk);
    checks++; if (dut.ceb !== 2'b10) begin failures++; $display("FAIL sel_rd0_ceb: got %b expected 10", dut.ceb); end
    tick();
    rd_addr = 11'h105;
    @(negedge clk);
    checks++; if (dut.ceb !== 2'b01) begin failures++; $display("FAIL sel_rd1_ceb: got %b expected 01", dut.ceb); end
    if (LAT == 1) begin
      checks++; if (rd_data !== row_a) begin failures++; $display("FAIL sel_rd0_data: got %h expected %h", rd_data, row_a); end
    end
    tick();
    rd_en = 1'b0;
    if (LAT == 2) begin
      checks++; if (rd_data !== row_a) begin failures++; $display("FAIL sel_rd0_data: got %h expected %h", rd_data, row_a); end
      tick();
    end
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL sel_rd1_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_data !== row_b) begin failures++; $display("FAIL sel_rd1_data: got %h expected %h", rd_data, row_b); end
    tick();
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_addr = 11'h005; wr_data = row_c;
    rd_en = 1'b1; rd_addr = 11'h005;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL b2b_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (rd_ready !== 1'b0) begin failures++; $display("FAIL b2b_rd_stall: got %b expected 0", rd_ready); end
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL b2b_rd_ready: got %b expected 1", rd_ready); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_valid: got %b expected 0", rd_valid); end
    tick();
    rd_en = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL b2b_rd_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_data !== row_c) begin failures++; $display("FAIL b2b_rd_data: got %h expected %h", rd_data, row_c); end
    tick();
  endtask

  task automatic test_chain();
    chain_en = 1'b1;
    wr_en = 1'b1; wr_addr = 11'h205; wr_data = row_d;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL chain_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (dut.ceb !== 2'b11) begin failures++; $display("FAIL chain_wr_ceb: got %b expected 11", dut.ceb); end
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 11'h005;
    tick();
    rd_en = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (rd_data !== row_c) begin failures++; $display("FAIL chain_hit_data: got %h expected %h", rd_data, row_c); end
    tick();
    rd_en = 1'b1; rd_addr = 11'h205;
    @(negedge clk);
    checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL chain_rd_ready: got %b expected 1", rd_ready); end
    checks++; if (dut.ceb !== 2'b11) begin failures++; $display("FAIL chain_rd_ceb: got %b expected 11", dut.ceb); end
    tick();
    rd_en = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL chain_miss_valid: got %b expected 0", rd_valid); end
      tick();
    end
    checks++; if (rd_data !== row_c) begin failures++; $display("FAIL chain_miss_hold: got %h expected %h", rd_data, row_c); end
    // Without filtering, 0x205 aliases macro 0 row 5, which the dropped write must not have touched.
    chain_en = 1'b0; rd_en = 1'b1; rd_addr = 11'h205;
    tick();
    rd_en = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL chain_alias_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_data !== row_c) begin failures++; $display("FAIL chain_alias_data: got %h expected %h", rd_data, row_c); end
    tick();
  endtask

  task automatic test_hold_clk_en();
    rd_en = 1'b1; rd_addr = 11'h105;
    tick();
    rd_en = 1'b0;
    repeat (LAT) tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL hold_valid: got %b expected 0", rd_valid); end
      checks++; if (rd_data !== row_b) begin failures++; $display("FAIL hold_data: got %h expected %h", rd_data, row_b); end
      tick();
    end
    wr_en = 1'b1; wr_addr = 11'h105; wr_data = row_e;
    tick();
    wr_en = 1'b0;
    repeat (LAT) tick();
    checks++; if (rd_data !== row_b) begin failures++; $display("FAIL hold_after_write: got %h expected %h", rd_data, row_b); end
    clk_en = 1'b0; wr_en = 1'b1; wr_addr = 11'h105; wr_data = row_d;
    rd_en = 1'b1; rd_addr = 11'h105;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if ({wr_ready, rd_ready} !== 2'b00) begin failures++; $display("FAIL clk_en_ready: got %b expected 00", {wr_ready, rd_ready}); end
      checks++; if (dut.ceb !== 2'b11) begin failures++; $display("FAIL clk_en_ceb: got %b expected 11", dut.ceb); end
      tick();
    end
    wr_en = 1'b0; clk_en = 1'b1;
    tick();
    clk_en = 1'b0; rd_en = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL clk_en_fall_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_data !== row_e) begin failures++; $display("FAIL clk_en_fall_data: got %h expected %h", rd_data, row_e); end
    clk_en = 1'b1;
    tick();
  endtask

  task automatic test_reset_midflight();
    rd_en = 1'b1; rd_addr = 11'h005;
    tick();
    rd_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b expected 0", rd_valid); end
    tick();
    rst = 1'b0;
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL rst_mid_data: got %h expected 0", rd_data); end
    for (int k = 0; k < LAT + 1; k++) begin
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_late_valid: got %b expected 0", rd_valid); end
      tick();
    end
  endtask

  initial begin
    row_a = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    row_b = {16'hBBB3, 16'hBBB2, 16'hBBB1, 16'hBBB0};
    row_c = {16'hC0DE, 16'h0123, 16'h4567, 16'h89AB};
    row_d = {16'hDEAD, 16'hBEEF, 16'hD00D, 16'hFACE};
    row_e = {16'hE003, 16'hE002, 16'hE001, 16'hE000};
    test_reset();
    test_basic();
    test_macro_select();
    test_back_to_back();
    test_chain();
    test_hold_clk_en();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
